// File: rtl/button_mode_ctrl_if.sv
// button_mode_ctrl_if: raw buttons in, debounced levels, press events, mode levels and command pulses out.
interface button_mode_ctrl_if #(parameter int NUM_BTN = 3);
    logic [NUM_BTN-1:0] btn, btn_level, evt_short, evt_long;
    logic mode_time, mode_alarm, inc_pulse, next_pulse, stop_pulse;
    modport master (
        output btn,
        input btn_level, evt_short, evt_long, mode_time, mode_alarm, inc_pulse, next_pulse, stop_pulse
    );
    modport slave (
        input btn,
        output btn_level, evt_short, evt_long, mode_time, mode_alarm, inc_pulse, next_pulse, stop_pulse
    );
endinterface

// File: rtl/button_mode_ctrl.sv
// button_mode_ctrl: button sync/debounce, short/long press classification and set-mode FSM.
// Define BTN_AUTOREPEAT_EN to auto-repeat inc_pulse while btn0 is held long in a set mode.
module button_mode_ctrl #(
    parameter int NUM_BTN = 3,
    parameter int DEB_CYCLES = 8,
    parameter int LONG_CYCLES = 16,
    parameter int REPEAT_CYCLES = 8,
    parameter int CNT_W = 8
) (
    input logic clock,
    input logic reset,
    button_mode_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] deb_last = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] long_last = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] long_max = CNT_W'(LONG_CYCLES);

    if (NUM_BTN < 3 || DEB_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("button_mode_ctrl: invalid parameters");
    end

    logic [NUM_BTN-1:0] level, evt_short, evt_long;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic s1, s2, lvl, fired;
        logic [CNT_W-1:0] deb, hold;
        always_ff @(posedge clock) begin
            if (!reset) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
                lvl <= 1'b0;
                fired <= 1'b0;
                deb <= '0;
                hold <= '0;
            end else begin
                s1 <= bus.btn[i];
                s2 <= s1;
                deb <= (s2 == lvl || deb == deb_last) ? '0 : deb + 1'b1;
                lvl <= (s2 != lvl && deb == deb_last) ? ~lvl : lvl;
                hold <= !lvl ? '0 : (hold == long_max) ? hold : hold + 1'b1;
                fired <= lvl && (fired || hold == long_last);
            end
        end
        // hold saturates past long_last, so the long event fires once per press
        assign level[i] = lvl;
        assign evt_long[i] = lvl && hold == long_last;
        assign evt_short[i] = !lvl && hold != '0 && !fired;
    end

    typedef enum logic [1:0] {IDLE = 2'b00, SET_TIME = 2'b01, SET_ALARM = 2'b10} state_t;
    state_t state;
    logic inc, adv, stop, set_mode, rpt_inc;
    assign set_mode = state != IDLE;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] rpt_last = CNT_W'(REPEAT_CYCLES - 1);
    logic rpt_on;
    logic [CNT_W-1:0] rpt;
    // repeating is armed only by a long btn0 press that started inside a set mode
    always_ff @(posedge clock) begin
        if (!reset || !set_mode || !level[0] || evt_long[2]) begin
            rpt_on <= 1'b0;
            rpt <= '0;
        end else if (evt_long[0]) begin
            rpt_on <= 1'b1;
            rpt <= '0;
        end else if (rpt_on) begin
            rpt <= (rpt == rpt_last) ? '0 : rpt + 1'b1;
        end
    end
    assign rpt_inc = evt_long[0] || (rpt_on && rpt == rpt_last);
`else
    assign rpt_inc = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            inc <= 1'b0;
            adv <= 1'b0;
            stop <= 1'b0;
        end else begin
            if (state == IDLE)
                state <= evt_long[0] ? SET_TIME : evt_long[1] ? SET_ALARM : IDLE;
            else if (evt_long[2])
                state <= IDLE;
            inc <= set_mode && (evt_short[0] || rpt_inc);
            adv <= set_mode && evt_short[1];
            stop <= set_mode && evt_long[2];
        end
    end

    assign bus.btn_level = level;
    assign bus.evt_short = evt_short;
    assign bus.evt_long = evt_long;
    assign bus.mode_time = state[0];
    assign bus.mode_alarm = state[1];
    assign bus.inc_pulse = inc;
    assign bus.next_pulse = adv;
    assign bus.stop_pulse = stop;
endmodule

// File: tb/tb_button_mode_ctrl.sv
// tb_button_mode_ctrl: directed checks of debounce, press classification, mode FSM and command pulses.
module tb_button_mode_ctrl;
    localparam int NB = 4;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    button_mode_ctrl_if #(.NUM_BTN(NB)) bus();

    button_mode_ctrl #(
        .NUM_BTN(NB), .DEB_CYCLES(4), .LONG_CYCLES(16), .REPEAT_CYCLES(4), .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0, n_fail = 0, cyc = 0, base = 0;
    int sc[NB], lc[NB], lvl_c[NB];
    int inc_c, next_c, stop_c, both_c;
    int f_short, f_long, f_inc, f_next, f_stop, f_mt1, f_mt0, f_ma1, f_lvl1;
    logic [63:0] inc_mask, exp_mask;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear();
        base = cyc;
        for (int i = 0; i < NB; i++) begin
            sc[i] = 0;
            lc[i] = 0;
            lvl_c[i] = 0;
        end
        inc_c = 0;
        next_c = 0;
        stop_c = 0;
        inc_mask = '0;
        f_short = -1;
        f_long = -1;
        f_inc = -1;
        f_next = -1;
        f_stop = -1;
        f_mt1 = -1;
        f_mt0 = -1;
        f_ma1 = -1;
        f_lvl1 = -1;
    endtask

    task automatic tick();
        int rel;
        @(posedge clock);
        #1;
        cyc++;
        rel = cyc - base;
        for (int i = 0; i < NB; i++) begin
            sc[i] += int'(bus.evt_short[i]);
            lc[i] += int'(bus.evt_long[i]);
            lvl_c[i] += int'(bus.btn_level[i]);
        end
        inc_c += int'(bus.inc_pulse);
        next_c += int'(bus.next_pulse);
        stop_c += int'(bus.stop_pulse);
        if (bus.mode_time && bus.mode_alarm) both_c++;
        if (bus.inc_pulse && rel < 64) inc_mask[rel] = 1'b1;
        if (|bus.evt_short && f_short < 0) f_short = rel;
        if (|bus.evt_long && f_long < 0) f_long = rel;
        if (bus.inc_pulse && f_inc < 0) f_inc = rel;
        if (bus.next_pulse && f_next < 0) f_next = rel;
        if (bus.stop_pulse && f_stop < 0) f_stop = rel;
        if (bus.mode_time && f_mt1 < 0) f_mt1 = rel;
        if (!bus.mode_time && f_mt0 < 0) f_mt0 = rel;
        if (bus.mode_alarm && f_ma1 < 0) f_ma1 = rel;
        if (bus.btn_level[1] && f_lvl1 < 0) f_lvl1 = rel;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.btn_level, bus.evt_short, bus.evt_long, bus.mode_time,
                    bus.mode_alarm, bus.inc_pulse, bus.next_pulse, bus.stop_pulse});
    endfunction

    initial begin
        bus.btn = '0;
        both_c = 0;
        clear();
        run(2);
        check("reset_outputs", all_outputs(), 0);
        reset = 1'b1;
        run(2);

        // 3-cycle glitch never reaches the 4-cycle debounce threshold
        clear();
        bus.btn[0] = 1'b1;
        run(3);
        bus.btn[0] = 1'b0;
        run(10);
        check("glitch_level", lvl_c[0], 0);
        check("glitch_events", sc[0] + lc[0], 0);
        check("glitch_mode", {bus.mode_time, bus.mode_alarm}, 0);

        // short btn1 in IDLE
        clear();
        bus.btn[1] = 1'b1;
        run(10);
        bus.btn[1] = 1'b0;
        run(12);
        check("t2_rise_latency", f_lvl1, 6);
        check("t2_short_count", sc[1], 1);
        check("t2_short_cycle", f_short, 16);
        check("t2_long_count", lc[1], 0);
        check("t2_next_pulse", next_c, 0);
        check("t2_mode", {bus.mode_time, bus.mode_alarm}, 0);

        // long btn0 in IDLE enters SET_TIME
        clear();
        bus.btn[0] = 1'b1;
        run(40);
        bus.btn[0] = 1'b0;
        run(10);
        check("t3_long_cycle", f_long, 21);
        check("t3_long_count", lc[0], 1);
        check("t3_mode_time_cycle", f_mt1, 22);
        check("t3_no_short", sc[0], 0);
        check("t3_mode_time", bus.mode_time, 1);
        check("t3_no_inc", inc_c, 0);

        // short btn0 in SET_TIME gives one inc_pulse
        clear();
        bus.btn[0] = 1'b1;
        run(6);
        bus.btn[0] = 1'b0;
        run(14);
        check("t4_inc_cycle", f_inc, 13);
        check("t4_inc_count", inc_c, 1);
        check("t4_next_count", next_c, 0);

        // long btn2 leaves SET_TIME with stop_pulse
        clear();
        bus.btn[2] = 1'b1;
        run(25);
        bus.btn[2] = 1'b0;
        run(12);
        check("t4_stop_cycle", f_stop, 22);
        check("t4_mode_drop_cycle", f_mt0, 22);
        check("t4_stop_count", stop_c, 1);
        check("t4_mode_after_exit", {bus.mode_time, bus.mode_alarm}, 0);

        // long btn2 in IDLE is ignored
        clear();
        bus.btn[2] = 1'b1;
        run(25);
        bus.btn[2] = 1'b0;
        run(12);
        check("t4_idle_long2", lc[2], 1);
        check("t4_idle_no_stop", stop_c, 0);
        check("t4_idle_mode", {bus.mode_time, bus.mode_alarm}, 0);

        // simultaneous long btn0/btn1: SET_TIME wins
        clear();
        bus.btn[0] = 1'b1;
        bus.btn[1] = 1'b1;
        run(24);
        check("t5_long_both", {lc[0][3:0], lc[1][3:0]}, 8'h11);
        check("t5_mode_time_cycle", f_mt1, 22);
        check("t5_modes", {bus.mode_time, bus.mode_alarm}, 2'b10);

        // reset mid-press with btn1 still held
        bus.btn[0] = 1'b0;
        reset = 1'b0;
        run(1);
        check("t5_reset_outputs", all_outputs(), 0);
        reset = 1'b1;
        clear();
        run(24);
        check("t5_relevel_latency", f_lvl1, 6);
        check("t5_fresh_hold_alarm", f_ma1, 22);
        check("t5_modes_after_reset", {bus.mode_time, bus.mode_alarm}, 2'b01);
        bus.btn[1] = 1'b0;
        run(12);
        check("t5_no_short", sc[1], 0);

        // long btn0 in SET_ALARM: auto-repeat only when built in
        clear();
        bus.btn[0] = 1'b1;
        run(30);
        bus.btn[0] = 1'b0;
        run(15);
`ifdef BTN_AUTOREPEAT_EN
        exp_mask = (64'd1 << 22) | (64'd1 << 26) | (64'd1 << 30) | (64'd1 << 34);
`else
        exp_mask = '0;
`endif
        check("t6_inc_mask", inc_mask, exp_mask);
        check("t6_long_count", lc[0], 1);
        check("t6_no_short", sc[0], 0);
        check("t6_mode_alarm", {bus.mode_time, bus.mode_alarm}, 2'b01);

        // simultaneous short btn0/btn1 in SET_ALARM
        clear();
        bus.btn[0] = 1'b1;
        bus.btn[1] = 1'b1;
        run(6);
        bus.btn[0] = 1'b0;
        bus.btn[1] = 1'b0;
        run(14);
        check("t7_inc_cycle", f_inc, 13);
        check("t7_next_cycle", f_next, 13);
        check("t7_pulse_counts", {inc_c[3:0], next_c[3:0]}, 8'h11);

        // btn3 only produces events, no commands or mode change
        clear();
        bus.btn[3] = 1'b1;
        run(6);
        bus.btn[3] = 1'b0;
        run(14);
        bus.btn[3] = 1'b1;
        run(25);
        bus.btn[3] = 1'b0;
        run(12);
        check("t8_btn3_events", {sc[3][3:0], lc[3][3:0]}, 8'h11);
        check("t8_btn3_no_cmds", inc_c + next_c + stop_c, 0);
        check("t8_btn3_mode", {bus.mode_time, bus.mode_alarm}, 2'b01);

        check("modes_exclusive", both_c, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
